// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON round sequencer: round-count table,
// datapath select-bit positions, FSM state encoding and select decode.
package simon_pkg;

  localparam int SEL_W    = 16;
  localparam int CNT_W    = 7;

  // Bit positions inside select_out
  localparam int SEL_STEP = 0;  // [1:0] micro-step index
  localparam int SEL_IN   = 2;  // load input word
  localparam int SEL_SWAP = 3;  // swap halves at end of round
  localparam int SEL_KEY  = 4;  // capture key
  localparam int SEL_DEC  = 5;  // decrypt direction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP1,
    ST_STEP2,
    ST_STEP3,
    ST_DONE
  } state_t;

  // Round count for a legal (word, key) pair; 0 flags an illegal pair.
  function automatic int simon_rounds(input int word, input int key);
    int r;
    r = 0;
    if      (word == 16 && key == 64)  r = 32;
    else if (word == 24 && key == 72)  r = 36;
    else if (word == 24 && key == 96)  r = 36;
    else if (word == 32 && key == 96)  r = 42;
    else if (word == 32 && key == 128) r = 44;
    else if (word == 48 && key == 96)  r = 52;
    else if (word == 48 && key == 144) r = 54;
    else if (word == 64 && key == 128) r = 68;
    else if (word == 64 && key == 192) r = 69;
    else if (word == 64 && key == 256) r = 72;
    return r;
  endfunction

  // Datapath mux selects presented while in state s.
  function automatic logic [SEL_W-1:0] sel_bits(input state_t s, input logic dec);
    logic [SEL_W-1:0] v;
    v = '0;
    case (s)
      ST_LOAD: begin
        v[SEL_IN]  = 1'b1;
        v[SEL_KEY] = 1'b1;
        v[SEL_DEC] = dec;
      end
      ST_STEP1: begin
        v[SEL_STEP+:2] = 2'b00;
        v[SEL_DEC]     = dec;
      end
      ST_STEP2: begin
        v[SEL_STEP+:2] = 2'b01;
        v[SEL_DEC]     = dec;
      end
      ST_STEP3: begin
        v[SEL_STEP+:2] = 2'b10;
        v[SEL_SWAP]    = 1'b1;
        v[SEL_DEC]     = dec;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/simon_round_counter.sv
// 7-bit loadable up/down round counter with terminal-count compare.
module simon_round_counter
  import simon_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  input  logic             down,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             at_terminal
);

  // Load wins over counting; count moves one step per enabled cycle
  always_ff @(posedge clk) begin
    if (!reset)      count <= '0;
    else if (load)   count <= load_value;
    else if (enable) count <= down ? count - 1'b1 : count + 1'b1;
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/simon_round_ctrl.sv
// SIMON round sequencer: LOAD then three micro-steps per round, with
// stall support, start/busy/done handshake and key-schedule round index.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int KEY_SIZE  = 128,
  parameter int ROUNDS    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             stall,
  output logic [SEL_W-1:0] select_out,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             done,
  output logic             last_round
);

  localparam int R_DERIVED = simon_rounds(WORD_SIZE, KEY_SIZE);
  localparam int R         = (ROUNDS != 0) ? ROUNDS : R_DERIVED;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

  generate
    if (R < 1 || R > 127) begin : g_bad_rounds
      $error("simon_round_ctrl: illegal WORD_SIZE/KEY_SIZE pair or ROUNDS out of range");
    end
  endgenerate

  state_t           state, state_nxt;
  logic             mode_q, mode_nxt;
  logic             in_step;
  logic             accept;
  logic             cnt_en;
  logic [CNT_W-1:0] count;
  logic             at_term;

  assign accept = (state == ST_IDLE) && start;
  // Final STEP3 exits to DONE without touching the counter, so it never wraps
  assign cnt_en = (state == ST_STEP3) && !stall && !at_term;

  simon_round_counter u_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .load_value  (mode ? LAST : '0),
    .enable      (cnt_en),
    .down        (mode_q),
    .terminal    (mode_q ? '0 : LAST),
    .count       (count),
    .at_terminal (at_term)
  );

  // Next-state and mode capture; stall freezes only LOAD/STEP states
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    case (state)
      ST_IDLE:  if (start) begin
                  state_nxt = ST_LOAD;
                  mode_nxt  = mode;
                end
      ST_LOAD:  if (!stall) state_nxt = ST_STEP1;
      ST_STEP1: if (!stall) state_nxt = ST_STEP2;
      ST_STEP2: if (!stall) state_nxt = ST_STEP3;
      ST_STEP3: if (!stall) state_nxt = at_term ? ST_DONE : ST_STEP1;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they are registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      select_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_step    <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      select_out <= sel_bits(state_nxt, mode_nxt);
      busy       <= (state_nxt != ST_IDLE);
      done       <= (state_nxt == ST_DONE);
      in_step    <= (state_nxt == ST_STEP1) || (state_nxt == ST_STEP2) ||
                    (state_nxt == ST_STEP3);
    end
  end

  // Round index is only meaningful during steps; held at zero elsewhere
  assign round_idx  = in_step ? count : '0;
  assign last_round = in_step && at_term;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: a 32/128 instance (R=44) and a
// 16/64 instance (R=32). Stimulus pushes the expected output stream; the
// monitor pops one entry per busy cycle and checks idle outputs otherwise.
module tb_simon_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, mode0, stall0, start1, mode1, stall1;
  logic [15:0] sel0, sel1;
  logic [6:0]  idx0, idx1;
  logic busy0, busy1, done0, done1, last0, last1;

  simon_round_ctrl #(.WORD_SIZE(32), .KEY_SIZE(128), .ROUNDS(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .mode(mode0), .stall(stall0),
    .select_out(sel0), .round_idx(idx0), .busy(busy0), .done(done0), .last_round(last0));

  simon_round_ctrl #(.WORD_SIZE(16), .KEY_SIZE(64), .ROUNDS(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .stall(stall1),
    .select_out(sel1), .round_idx(idx1), .busy(busy1), .done(done1), .last_round(last1));

  typedef struct packed {
    logic [15:0] sel;
    logic [6:0]  idx;
    logic        last;
    logic        done;
  } exp_t;

  exp_t q0[$], q1[$];
  int cyc = 0;
  int nvec = 0, nerr = 0;
  int ndone0 = 0, ndone1 = 0, dedge0 = 0, dedge1 = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input exp_t act, input exp_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0d: got sel=%h idx=%0d last=%b done=%b, want sel=%h idx=%0d last=%b done=%b",
               name, cyc, act.sel, act.idx, act.last, act.done, exp.sel, exp.idx, exp.last, exp.done);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected stream: LOAD, 3 steps per round, DONE; stalled position repeated
  function automatic void push_seq(input int d, input bit m, input int R,
                                   input int sp, input int sl, input int trunc);
    exp_t e;
    int n = 0;
    for (int p = 0; p <= 3 * R + 1; p++) begin
      int r, st;
      e = '0;
      if (p == 0) begin
        e.sel = 16'h0014;
      end else if (p == 3 * R + 1) begin
        e.done = 1'b1;
      end else begin
        r  = (p - 1) / 3;
        st = (p - 1) % 3;
        e.sel  = (st == 0) ? 16'h0000 : (st == 1) ? 16'h0001 : 16'h000A;
        e.idx  = 7'(m ? R - 1 - r : r);
        e.last = (r == R - 1);
      end
      if (p != 3 * R + 1 && m) e.sel = e.sel | 16'h0020;
      for (int j = 0; j < ((p == sp) ? 1 + sl : 1); j++) begin
        if (trunc == 0 || n < trunc) begin
          if (d == 0) q0.push_back(e); else q1.push_back(e);
          n++;
        end
      end
    end
  endfunction

  task automatic mon_dut(input int d, input logic [15:0] s, input logic [6:0] i,
                         input logic l, input logic dn, input logic b);
    exp_t a, e;
    a = '{s, i, l, dn};
    if (b) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        nvec++; nerr++;
        $display("FAIL dut%0d_unexpected_busy @%0d: got busy=1, want busy=0", d, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("dut%0d_stream", d), a, e);
      end
      if (dn) begin
        if (d == 0) begin ndone0++; dedge0 = cyc + 1; end
        else        begin ndone1++; dedge1 = cyc + 1; end
      end
    end else begin
      cmp($sformatf("dut%0d_idle", d), a, '0);
    end
  endtask

  // Monitor: away from the rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      mon_dut(0, sel0, idx0, last0, done0, busy0);
      mon_dut(1, sel1, idx1, last1, done1, busy1);
    end
  end

  task automatic drive(input int d, input logic st, input logic md, input logic sl);
    if (d == 0) begin start0 = st; mode0 = md; stall0 = sl; end
    else        begin start1 = st; mode1 = md; stall1 = sl; end
  endtask

  // sp/sl: stall position and length; spur: extra start at that position;
  // spur_done: extra start during DONE; rst_p: reset at that position
  task automatic run(input int d, input bit m, input int sp, input int sl,
                     input int spur, input bit spur_done, input int rst_p,
                     input bit start_stall);
    int R, k, nd, c;
    logic st, stl;
    R = (d == 0) ? 44 : 32;
    push_seq(d, m, R, sp, sl, (rst_p >= 0) ? rst_p + 1 : 0);
    @(negedge clk);
    k  = cyc + 1;
    nd = (d == 0) ? ndone0 : ndone1;
    drive(d, 1'b1, m, start_stall);
    for (int i = 0; i < 3 * R + sl + 8; i++) begin
      @(negedge clk);
      c   = cyc;
      st  = (spur > 0 && c == k + spur) || (spur_done && c == k + 1 + 3 * R + sl);
      stl = (sl > 0 && c >= k + sp && c < k + sp + sl);
      drive(d, st, ~m, stl);
      reset = !(rst_p >= 0 && c == k + rst_p);
    end
    drive(d, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    if (rst_p >= 0) begin
      cmp_int($sformatf("dut%0d_no_done_after_reset", d), ((d == 0) ? ndone0 : ndone1) - nd, 0);
    end else begin
      cmp_int($sformatf("dut%0d_done_count", d), ((d == 0) ? ndone0 : ndone1) - nd, 1);
      cmp_int($sformatf("dut%0d_latency", d), ((d == 0) ? dedge0 : dedge1) - k, 3 * R + 2 + sl);
    end
    cmp_int($sformatf("dut%0d_queue_drained", d), (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    run(0, 1'b0, -1, 0, 0,  1'b0, -1, 1'b0);  // encrypt, no stall
    run(0, 1'b1, -1, 0, 0,  1'b0, -1, 1'b0);  // decrypt, no stall
    run(0, 1'b0, 32, 5, 0,  1'b0, -1, 1'b0);  // stall 5 in round 10 STEP2
    run(0, 1'b1, -1, 0, 12, 1'b1, -1, 1'b0);  // starts in round 3 STEP3 and DONE
    run(0, 1'b0, -1, 0, 0,  1'b0, 61, 1'b0);  // reset in round 20 STEP1
    run(0, 1'b0, -1, 0, 0,  1'b0, -1, 1'b1);  // start with stall in IDLE, full rerun
    run(1, 1'b0, -1, 0, 0,  1'b0, -1, 1'b0);  // 16/64 encrypt
    run(1, 1'b1, 0,  2, 0,  1'b0, -1, 1'b0);  // 16/64 decrypt, stall 2 in LOAD

    repeat (3) @(negedge clk);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
